apb4_bridge_q: RTL and testbench

//  Parametrised APB4 requester bridge, next generation of the single-shot APB bridge. A valid/ready

---
 rtl/apb4_bridge_q.sv | 164 ++++++++++++++++
 tb/tb_apb4_bridge_q.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_bridge_q.sv
// Queued APB4 requester: a valid/ready request FIFO feeds a single SETUP/ACCESS engine that decodes
// the address into one of COMP completers and returns rdata/err on a valid/ready response port.
module apb4_bridge_q #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int COMP       = 4,
    parameter int IDX_LSB    = 12,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 16,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_W      = $clog2(COMP)
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    input  logic [STRB_WIDTH-1:0]      req_strb,
    input  logic [2:0]                 req_prot,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic [COMP-1:0]            PSELx,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [ADDR_WIDTH-1:0]      PADDR,
    output logic [DATA_WIDTH-1:0]      PWDATA,
    output logic [STRB_WIDTH-1:0]      PSTRB,
    output logic [2:0]                 PPROT,
    input  logic [COMP-1:0]            PREADY,
    input  logic [COMP-1:0]            PSLVERR,
    input  logic [COMP*DATA_WIDTH-1:0] PRDATA
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [STRB_WIDTH-1:0] strb;
        logic [2:0]            prot;
    } req_t;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    req_t                           fifo_mem [DEPTH];
    req_t                           req_in;
    req_t                           head;
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic [PTR_W:0]                 count;
    logic [PTR_W:0]                 count_nxt;
    logic                           push;
    logic                           pop;
    logic                           hit;
    logic [IDX_W-1:0]               head_idx;
    logic [IDX_W-1:0]               idx_q;
    logic [CNT_W-1:0]               wait_cnt;
    state_t                         state;
    logic [COMP-1:0][DATA_WIDTH-1:0] prdata_a;

    assign req_in    = '{write: req_write, addr: req_addr, wdata: req_wdata, strb: req_strb, prot: req_prot};
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign count_nxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    assign head      = fifo_mem[rd_ptr];
    assign head_idx  = head.addr[IDX_LSB +: IDX_W];
    // Any address bit above the index field set, or an index >= COMP, is a decode miss.
    assign hit       = (head.addr >> IDX_LSB) < ADDR_WIDTH'(COMP);
    assign prdata_a  = PRDATA;

    always_ff @(posedge PCLK) begin
        if (push) fifo_mem[wr_ptr] <= req_in;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            req_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count_nxt;
            req_ready <= (count_nxt != (PTR_W+1)'(DEPTH));
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            idx_q     <= '0;
            wait_cnt  <= '0;
            PSELx     <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            PPROT     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) begin
                    PWRITE   <= head.write;
                    PADDR    <= head.addr;
                    PWDATA   <= head.wdata;
                    PSTRB    <= head.write ? head.strb : '0;
                    PPROT    <= head.prot;
                    idx_q    <= head_idx;
                    wait_cnt <= '0;
                    if (hit) begin
                        PSELx <= COMP'(1) << head_idx;
                        state <= SETUP;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY[idx_q]) begin
                        PSELx     <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR[idx_q];
                        rsp_rdata <= (!PWRITE && !PSLVERR[idx_q]) ? prdata_a[idx_q] : '0;
                        state     <= RESP;
                    end else if (TIMEOUT != 0 && wait_cnt == CNT_W'(TIMEOUT-1)) begin
                        PSELx     <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_bridge_q.sv
// Scoreboard bench for apb4_bridge_q: a completer model with per-completer wait/error settings,
// expected responses computed from the address map at push time, and a decoupled output monitor.
module tb_apb4_bridge_q;

    localparam int AW = 32, DW = 32, NC = 4, ILSB = 12, DEP = 4, TMO = 16, SW = DW / 8;

    logic             PCLK = 1'b0;
    logic             PRESETn = 1'b1;
    logic             req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [AW-1:0]    req_addr = '0;
    logic [DW-1:0]    req_wdata = '0;
    logic [SW-1:0]    req_strb = '0;
    logic [2:0]       req_prot = '0;
    logic             req_ready, rsp_valid, rsp_err, PENABLE, PWRITE;
    logic [DW-1:0]    rsp_rdata, PWDATA;
    logic [NC-1:0]    PSELx, PREADY, PSLVERR;
    logic [AW-1:0]    PADDR;
    logic [SW-1:0]    PSTRB;
    logic [2:0]       PPROT;
    logic [NC*DW-1:0] PRDATA;

    apb4_bridge_q #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .COMP(NC), .IDX_LSB(ILSB),
                    .DEPTH(DEP), .TIMEOUT(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PSTRB(PSTRB), .PPROT(PPROT), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    int            checks = 0, errors = 0, cyc = 0, rsp_mode = 0, acc_cnt;
    int            wait_cfg [NC];
    int            wopts [6] = '{0, 1, 2, 15, 16, 255};
    logic [NC-1:0] err_cfg = '0, nz_r, nz_e;
    logic [DW-1:0] nz_d;
    logic          fixed_en = 1'b0;

    typedef struct { logic [DW-1:0] rdata; logic err; int stamp; int lat; } exp_t;
    typedef struct { logic [NC-1:0] sel; logic [AW-1:0] addr; logic wr; logic [DW-1:0] wdata;
                     logic [SW-1:0] strb; logic [2:0] prot; } xf_t;
    exp_t sb_q[$];
    xf_t  xf_q[$];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a, input logic fx);
        return fx ? 32'h1234_5678 : (a ^ 32'h3C3C_A5A5) + 32'h0000_0101;
    endfunction

    // Completers: selected one follows its wait/error setting; unselected ones drive noise.
    always @(posedge PCLK) begin
        cyc  <= cyc + 1;
        nz_r <= NC'($urandom);
        nz_e <= NC'($urandom);
        nz_d <= $urandom;
    end

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) acc_cnt <= 0;
        else if (PENABLE && !(|(PREADY & PSELx))) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always_comb begin
        PREADY  = '0;
        PSLVERR = '0;
        PRDATA  = '0;
        for (int i = 0; i < NC; i++) begin
            if (PSELx[i] && PENABLE) begin
                PREADY[i]          = (acc_cnt >= wait_cfg[i]);
                PSLVERR[i]         = err_cfg[i];
                PRDATA[i*DW +: DW] = data_of(PADDR, fixed_en);
            end else begin
                PREADY[i]          = nz_r[i];
                PSLVERR[i]         = nz_e[i];
                PRDATA[i*DW +: DW] = nz_d;
            end
        end
    end

    initial begin
        forever begin
            @(posedge PCLK);
            #1;
            rsp_ready = (rsp_mode == 1) ? 1'b1 : (rsp_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: APB transfer checks against pushed transfers, response checks against the scoreboard.
    initial begin
        logic          seen, he;
        logic [DW-1:0] hd;
        xf_t           cur;
        exp_t          e;
        seen = 1'b0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) seen = 1'b0;
            else begin
                chk("psel_onehot0", 64'($countones(PSELx) <= 1), 64'(1));
                if (PSELx == '0) chk("penable_without_psel", 64'(PENABLE), 64'(0));
                else if (!PENABLE) begin
                    if (xf_q.size() == 0) chk("unexpected_setup", 64'(PSELx), 64'(0));
                    else begin
                        cur = xf_q.pop_front();
                        chk("setup_psel", 64'(PSELx), 64'(cur.sel));
                        chk("setup_paddr", 64'(PADDR), 64'(cur.addr));
                        chk("setup_pwrite", 64'(PWRITE), 64'(cur.wr));
                        chk("setup_pstrb", 64'(PSTRB), 64'(cur.strb));
                        chk("setup_pprot", 64'(PPROT), 64'(cur.prot));
                        if (cur.wr) chk("setup_pwdata", 64'(PWDATA), 64'(cur.wdata));
                    end
                end else begin
                    chk("access_psel_stable", 64'(PSELx), 64'(cur.sel));
                    chk("access_paddr_stable", 64'(PADDR), 64'(cur.addr));
                end
                if (rsp_valid) begin
                    if (!seen) begin
                        seen = 1'b1;
                        hd   = rsp_rdata;
                        he   = rsp_err;
                        if (sb_q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
                        else begin
                            e = sb_q[0];
                            chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                            chk("rsp_err", 64'(rsp_err), 64'(e.err));
                            if (e.lat >= 0) chk("rsp_latency", 64'(cyc - e.stamp), 64'(e.lat));
                        end
                    end else begin
                        chk("rsp_rdata_hold", 64'(rsp_rdata), 64'(hd));
                        chk("rsp_err_hold", 64'(rsp_err), 64'(he));
                    end
                    if (rsp_ready) begin
                        seen = 1'b0;
                        if (sb_q.size() != 0) sb_q.delete(0);
                    end
                end else if (seen) begin
                    chk("rsp_valid_dropped", 64'(rsp_valid), 64'(1));
                    seen = 1'b0;
                end
            end
        end
    end

    // Drive one request; the expected outcome comes from the address map and completer settings.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic [2:0] p, input int lat);
        int   n, pg;
        exp_t e;
        xf_t  x;
        @(negedge PCLK);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s; req_prot = p;
        n = 0;
        while (!req_ready && n < 500) begin
            @(negedge PCLK);
            n++;
        end
        if (!req_ready) chk("req_ready_wait", 64'(req_ready), 64'(1));
        else begin
            pg      = int'(a >> ILSB);
            e.stamp = cyc;
            e.lat   = lat;
            if (pg >= NC) begin
                e.err = 1'b1; e.rdata = '0;
            end else if (TMO != 0 && wait_cfg[pg] >= TMO) begin
                e.err = 1'b1; e.rdata = '0;
            end else begin
                e.err   = err_cfg[pg];
                e.rdata = (!w && !e.err) ? data_of(a, fixed_en) : '0;
            end
            sb_q.push_back(e);
            if (pg < NC) begin
                x.sel = NC'(1) << pg; x.addr = a; x.wr = w; x.wdata = d;
                x.strb = w ? s : '0; x.prot = p;
                xf_q.push_back(x);
            end
        end
        @(posedge PCLK);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(negedge PCLK);
            n++;
        end
        chk("drain_rsp_left", 64'(sb_q.size()), 64'(0));
        chk("drain_xfer_left", 64'(xf_q.size()), 64'(0));
    endtask

    initial begin
        int n, len, pg;
        logic [AW-1:0] a;
        for (int i = 0; i < NC; i++) wait_cfg[i] = 0;
        #1 PRESETn = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_psel", 64'(PSELx), 64'(0));
        chk("rst_penable", 64'(PENABLE), 64'(0));
        chk("rst_pwrite", 64'(PWRITE), 64'(0));
        chk("rst_paddr", 64'(PADDR), 64'(0));
        chk("rst_pwdata", 64'(PWDATA), 64'(0));
        chk("rst_pstrb", 64'(PSTRB), 64'(0));
        chk("rst_pprot", 64'(PPROT), 64'(0));
        PRESETn = 1'b1;
        rsp_mode = 1;
        repeat (2) @(negedge PCLK);

        // Best-case write, then a read with three wait states.
        send(1'b1, 32'h0000_1004, 32'hA5A5_5A5A, 4'hF, 3'b010, 4);
        drain();
        wait_cfg[2] = 3; fixed_en = 1'b1;
        send(1'b0, 32'h0000_2008, 32'hDEAD_BEEF, 4'hF, 3'b001, 7);
        drain();
        wait_cfg[2] = 0; fixed_en = 1'b0;

        // Fill the FIFO behind a stalled response.
        rsp_mode = 0;
        @(posedge PCLK);
        #2;
        for (int k = 0; k <= DEP; k++)
            send(1'b1, 32'((k % NC) << ILSB) | 32'h40, $urandom, 4'h3, 3'b000, -1);
        @(negedge PCLK);
        chk("fifo_full_ready", 64'(req_ready), 64'(0));
        chk("stalled_rsp_valid", 64'(rsp_valid), 64'(1));
        rsp_mode = 1;
        drain();
        chk("ready_after_drain", 64'(req_ready), 64'(1));

        // Decode misses.
        send(1'b0, 32'h0000_4000, 32'h0, 4'h0, 3'b000, 2);
        send(1'b1, 32'hFFFF_0000, 32'h1111_2222, 4'hF, 3'b111, -1);
        drain();

        // Timeout on a completer that never answers.
        wait_cfg[0] = 255;
        send(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b000, 19);
        n = 0;
        while (!PENABLE && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        len = 0;
        while (PENABLE && len < 100) begin
            len++;
            @(negedge PCLK);
        end
        chk("timeout_access_len", 64'(len), 64'(TMO));
        chk("timeout_psel_drop", 64'(PSELx), 64'(0));
        drain();
        wait_cfg[0] = 0;

        // Wait states right at and just past the timeout limit.
        wait_cfg[1] = TMO - 1;
        send(1'b0, 32'h0000_1100, 32'h0, 4'h0, 3'b000, 4 + TMO - 1);
        drain();
        wait_cfg[1] = TMO;
        send(1'b0, 32'h0000_1104, 32'h0, 4'h0, 3'b000, 4 + TMO - 1);
        drain();
        wait_cfg[1] = 0;

        // PSLVERR with PREADY.
        err_cfg[3] = 1'b1; wait_cfg[3] = 1;
        send(1'b0, 32'h0000_3010, 32'h0, 4'h0, 3'b000, 5);
        send(1'b1, 32'h0000_3020, 32'h5555_AAAA, 4'hC, 3'b100, -1);
        drain();
        err_cfg = '0; wait_cfg[3] = 0;

        // Randomized batches.
        for (int b = 0; b < 5; b++) begin
            for (int i = 0; i < NC; i++) wait_cfg[i] = wopts[$urandom_range(0, 5)];
            err_cfg  = NC'($urandom) & NC'($urandom);
            rsp_mode = 2;
            for (int k = 0; k < 25; k++) begin
                pg = $urandom_range(0, NC + 1);
                a  = (AW'(pg) << ILSB) | AW'($urandom_range(0, 4095));
                if ($urandom_range(0, 9) == 0) a = $urandom;
                send(1'($urandom_range(0, 1)), a, $urandom, SW'($urandom), 3'($urandom), -1);
                repeat ($urandom_range(0, 2)) @(negedge PCLK);
            end
            drain();
        end
        for (int i = 0; i < NC; i++) wait_cfg[i] = 0;
        err_cfg = '0;

        // Reset in the middle of ACCESS with two requests queued.
        rsp_mode = 0;
        wait_cfg[0] = 255;
        for (int k = 0; k < 3; k++) send(1'b0, 32'h0000_0100 + 32'(k * 4), 32'h0, 4'h0, 3'b000, -1);
        n = 0;
        while (!PENABLE && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        chk("rst_reach_access", 64'(PENABLE), 64'(1));
        #2 PRESETn = 1'b0;
        sb_q.delete();
        xf_q.delete();
        #1;
        chk("rst_async_psel", 64'(PSELx), 64'(0));
        chk("rst_async_penable", 64'(PENABLE), 64'(0));
        wait_cfg[0] = 0;
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge PCLK);
            chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));
            chk("post_rst_psel", 64'(PSELx), 64'(0));
            chk("post_rst_req_ready", 64'(req_ready), 64'(1));
        end
        rsp_mode = 1;
        send(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'h5, 3'b011, 4);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
